mc_port_arbiter: RTL and testbench
==================================

# mc_port_arbiter

Shares the single memory-controller request/response port (`mc_req_*` / `mc_rsp_*`) between `PORTS` requesters, such as several `bps` instances or a `bps` plus a host loader. Requests are granted round-robin, and load requests are tagged with the requester index in the top bits of the read-control field. Returning responses are routed back by that tag, with the tag stripped. A per-requester outstanding-load counter stops any one requester from flooding the controller.

## Interface
- `PORTS`, 2: number of requesters, 2..8.
- `ID_WIDTH`, 1: tag width; must equal clog2(`PORTS`).
- `MAX_OUTSTANDING`, 16: maximum in-flight loads per requester, 1..255.

- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rq_ld` in `PORTS`: per-requester load request.
- `rq_st` in `PORTS`: per-requester store request.
- `rq_vadr` in `PORTS`*48: per-requester byte address, packed; port i at [48i+47:48i].
- `rq_wrd_rdctl` in `PORTS`*64: per-requester store data or load rdctl, packed.
- `rq_stall` out `PORTS`: request not accepted this cycle.
- `rs_push` out `PORTS`: per-requester response valid.
- `rs_rdctl` out 32: routed response rdctl, tag bits zeroed.
- `rs_data` out 64: routed response data.
- `rs_stall` in `PORTS`: requester cannot take responses.
- `mc_req_ld` out 1, `mc_req_st` out 1, `mc_req_vadr` out 48, `mc_req_wrd_rdctl` out 64: request to the memory controller.
- `mc_req_stall` in 1: controller back-pressure.
- `mc_rsp_push` in 1, `mc_rsp_rdctl` in 32, `mc_rsp_data` in 64: response from the controller.
- `mc_rsp_stall` out 1: back-pressure to the controller.

## Operation
- Request i is eligible when (`rq_ld`[i] | `rq_st`[i]) and the port is not blocked. A port is blocked when its `rq_ld`[i] is high and its count equals `MAX_OUTSTANDING`. Stores are never blocked.
- Grant: the first eligible port at or after pointer `rr`, searching upward with wrap. A grant occurs only when the issue slot is free. `rq_stall`[i] = ~grant[i].
- On grant:
  - Forward ld/st/vadr to the controller.
  - For loads, `mc_req_wrd_rdctl`[31:32-`ID_WIDTH`] = i. Bits [63:32] and the remaining low bits are passed through.
  - For stores, the data is passed unmodified.
  - Set `rr` to i+1 mod `PORTS`.
- A load grant increments `count`[i].
- Response path:
  - When `mc_rsp_push` is high, tag t = `mc_rsp_rdctl`[31:32-`ID_WIDTH`].
  - Next cycle: `rs_push`[t]=1; `rs_rdctl` = rdctl with the tag bits cleared; `rs_data` = data.
  - `count`[t] decrements in the cycle `mc_rsp_push` is high.
- Simultaneous increment and decrement on the same port leaves `count` unchanged.
- A decrement of a zero count saturates at 0. This covers responses arriving after a mid-operation reset.
- `mc_rsp_stall` = OR of `rs_stall`, registered.
- `rq_ld`[i] & `rq_st`[i] together is illegal. A simulation-only assertion fires on it, and the request is then forwarded as a load.
- Requesters must keep rdctl bits [31:32-`ID_WIDTH`] at zero.

## Timing
- Reset values:
  - All `mc_req_*` outputs 0.
  - `rs_push` 0, `rs_rdctl` 0, `rs_data` 0.
  - `mc_rsp_stall` 0.
  - `rq_stall` all 1 while `rst` is low.
  - `rr` = 0; all counts = 0.
- Issue slot without the macro: free iff `mc_req_stall` = 0. Outputs are combinational from the granted port (0-cycle latency).
- Response latency: exactly 1 cycle from `mc_rsp_push` to `rs_push`. No buffering: the controller must honour `mc_rsp_stall`.
- A reset mid-operation aborts any held request; it is not reissued.

## Configuration
- `MC_PORT_ARB_OUT_REG_EN` defined:
  - Request outputs come from a one-entry output register; latency is 1 cycle.
  - The slot is free iff the register is empty, or `mc_req_stall` = 0 (register drains this cycle).
  - The register holds its contents while `mc_req_stall` = 1.
- Undefined: combinational pass-through as described under Timing.

## Structure
- Shared package `mc_pkg`:
  - `MC_VADR_W`=48, `MC_WRD_W`=64, `MC_RDCTL_W`=32.
  - Tag-field position function.
  - Reused by `bps` and its testbenches.
- Sub-module `mc_rr_arbiter`: eligible vector plus pointer in, one-hot grant and index out, pointer update.

## Test plan
- `PORTS`=2. Both ports load continuously with `mc_req_stall`=0 -> grants alternate 0,1,0,1; rdctl 0x5 from port 1 appears as 0x80000005 on `mc_req_wrd_rdctl`.
- Response with `mc_rsp_rdctl`=0x80000005 and data 0xDEAD -> next cycle `rs_push`=2'b10, `rs_rdctl`=0x5, `rs_data`=0xDEAD.
- `MAX_OUTSTANDING`=2, port 0 issues 2 loads with no responses -> third load stalls and port 1 still wins. One response -> port 0 is granted again.
- `mc_req_stall` held for 5 cycles with both ports requesting -> `rq_stall`=2'b11 and outputs hold; after release, grant order resumes from `rr`.
- Port 0 store to address 0x40 while port 1 is at its load limit -> store granted; port 1's count is unchanged.
- Reset asserted with 3 loads outstanding -> counts 0 and outputs 0; a late response routes normally and its count stays 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared memory-controller port definitions: field widths and the location of the
// requester tag carried in the top bits of the load rdctl field.
package mc_pkg;

  localparam int MC_VADR_W  = 48;
  localparam int MC_WRD_W   = 64;
  localparam int MC_RDCTL_W = 32;

  function automatic int mc_tag_lsb(input int id_w);
    return MC_RDCTL_W - id_w;
  endfunction

  function automatic logic [MC_WRD_W-1:0] mc_tag_mask(input int id_w);
    return ((MC_WRD_W'(1) << id_w) - MC_WRD_W'(1)) << mc_tag_lsb(id_w);
  endfunction

endpackage

// File: rtl/mc_rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or above the pointer, with wrap;
// the pointer moves past the winner whenever a grant is issued.
module mc_rr_arbiter #(
  parameter int PORTS    = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    elig,
  output logic [PORTS-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_vld
);

  logic [ID_WIDTH-1:0] rr;
  logic [2*PORTS-1:0]  rot;

  assign rot = {elig, elig} >> rr;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (!grant_vld && rot[k]) begin
        grant_vld = 1'b1;
        grant_idx = ID_WIDTH'((int'(rr) + k) % PORTS);
      end
    end
    grant = grant_vld ? (PORTS'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr <= '0;
    end else if (grant_vld) begin
      rr <= (grant_idx == ID_WIDTH'(PORTS - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mc_port_arbiter.sv
// Shares one memory-controller port among PORTS requesters, tagging loads and routing
// responses by tag. MC_PORT_ARB_OUT_REG_EN adds a one-entry request output register.
module mc_port_arbiter
  import mc_pkg::*;
#(
  parameter int PORTS           = 2,
  parameter int ID_WIDTH        = 1,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            rq_ld,
  input  logic [PORTS-1:0]            rq_st,
  input  logic [PORTS*MC_VADR_W-1:0]  rq_vadr,
  input  logic [PORTS*MC_WRD_W-1:0]   rq_wrd_rdctl,
  output logic [PORTS-1:0]            rq_stall,
  output logic [PORTS-1:0]            rs_push,
  output logic [MC_RDCTL_W-1:0]       rs_rdctl,
  output logic [MC_WRD_W-1:0]         rs_data,
  input  logic [PORTS-1:0]            rs_stall,
  output logic                        mc_req_ld,
  output logic                        mc_req_st,
  output logic [MC_VADR_W-1:0]        mc_req_vadr,
  output logic [MC_WRD_W-1:0]         mc_req_wrd_rdctl,
  input  logic                        mc_req_stall,
  input  logic                        mc_rsp_push,
  input  logic [MC_RDCTL_W-1:0]       mc_rsp_rdctl,
  input  logic [MC_WRD_W-1:0]         mc_rsp_data,
  output logic                        mc_rsp_stall
);

  localparam int                    TAG_LSB    = mc_tag_lsb(ID_WIDTH);
  localparam logic [MC_WRD_W-1:0]   TAG_MASK   = mc_tag_mask(ID_WIDTH);
  localparam logic [MC_RDCTL_W-1:0] RDCTL_MASK = TAG_MASK[MC_RDCTL_W-1:0];
  localparam logic [7:0]            MAX_CNT    = 8'(MAX_OUTSTANDING);

  logic [7:0]           cnt [PORTS];
  logic [PORTS-1:0]     elig;
  logic [PORTS-1:0]     elig_m;
  logic [PORTS-1:0]     grant;
  logic [ID_WIDTH-1:0]  grant_idx;
  logic                 grant_vld;
  logic                 slot_free;
  logic                 sel_ld;
  logic                 sel_st;
  logic [MC_VADR_W-1:0] sel_vadr;
  logic [MC_WRD_W-1:0]  sel_wrd;
  logic [PORTS-1:0]     cnt_inc;
  logic [PORTS-1:0]     cnt_dec;
  logic [ID_WIDTH-1:0]  rsp_tag;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      elig[i] = (rq_ld[i] | rq_st[i]) & ~(rq_ld[i] & (cnt[i] == MAX_CNT));
    end
  end

  assign elig_m = slot_free ? elig : '0;

  mc_rr_arbiter #(
    .PORTS    (PORTS),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .elig      (elig_m),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign rq_stall = ~grant;

  // A load wins over a simultaneous store on the same port; loads carry the port tag.
  always_comb begin
    sel_ld   = 1'b0;
    sel_st   = 1'b0;
    sel_vadr = '0;
    sel_wrd  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant[i]) begin
        sel_ld   = rq_ld[i];
        sel_st   = rq_st[i] & ~rq_ld[i];
        sel_vadr = rq_vadr[MC_VADR_W*i +: MC_VADR_W];
        sel_wrd  = rq_wrd_rdctl[MC_WRD_W*i +: MC_WRD_W];
      end
    end
    if (sel_ld) begin
      sel_wrd = (sel_wrd & ~TAG_MASK) | (MC_WRD_W'(grant_idx) << TAG_LSB);
    end
  end

  assign rsp_tag = mc_rsp_rdctl[MC_RDCTL_W-1 -: ID_WIDTH];
  assign cnt_inc = grant & {PORTS{sel_ld}};
  assign cnt_dec = mc_rsp_push ? (PORTS'(1) << rsp_tag) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PORTS; i++) cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          cnt[i] <= cnt[i] + 8'd1;
        end else if (cnt_dec[i] && !cnt_inc[i] && (cnt[i] != 8'd0)) begin
          cnt[i] <= cnt[i] - 8'd1;
        end
      end
    end
  end

`ifdef MC_PORT_ARB_OUT_REG_EN
  logic                 req_ld_p1;
  logic                 req_st_p1;
  logic [MC_VADR_W-1:0] req_vadr_p1;
  logic [MC_WRD_W-1:0]  req_wrd_p1;

  assign slot_free = rst & (~(req_ld_p1 | req_st_p1) | ~mc_req_stall);

  // Request stage p1: one-entry register, held while the controller stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ld_p1   <= 1'b0;
      req_st_p1   <= 1'b0;
      req_vadr_p1 <= '0;
      req_wrd_p1  <= '0;
    end else if (grant_vld) begin
      req_ld_p1   <= sel_ld;
      req_st_p1   <= sel_st;
      req_vadr_p1 <= sel_vadr;
      req_wrd_p1  <= sel_wrd;
    end else if (!mc_req_stall) begin
      req_ld_p1   <= 1'b0;
      req_st_p1   <= 1'b0;
    end
  end

  assign mc_req_ld        = req_ld_p1;
  assign mc_req_st        = req_st_p1;
  assign mc_req_vadr      = req_vadr_p1;
  assign mc_req_wrd_rdctl = req_wrd_p1;
`else
  assign slot_free        = rst & ~mc_req_stall;
  assign mc_req_ld        = sel_ld;
  assign mc_req_st        = sel_st;
  assign mc_req_vadr      = sel_vadr;
  assign mc_req_wrd_rdctl = sel_wrd;
`endif

  logic [PORTS-1:0]      rsp_vld_p1;
  logic [MC_RDCTL_W-1:0] rsp_rdctl_p1;
  logic [MC_WRD_W-1:0]   rsp_data_p1;
  logic                  rsp_stall_p1;

  // Response stage p1: route by tag and strip it; no buffering behind it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld_p1   <= '0;
      rsp_rdctl_p1 <= '0;
      rsp_data_p1  <= '0;
      rsp_stall_p1 <= 1'b0;
    end else begin
      rsp_vld_p1   <= cnt_dec;
      rsp_stall_p1 <= |rs_stall;
      if (mc_rsp_push) begin
        rsp_rdctl_p1 <= mc_rsp_rdctl & ~RDCTL_MASK;
        rsp_data_p1  <= mc_rsp_data;
      end
    end
  end

  assign rs_push      = rsp_vld_p1;
  assign rs_rdctl     = rsp_rdctl_p1;
  assign rs_data      = rsp_data_p1;
  assign mc_rsp_stall = rsp_stall_p1;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(|(rq_ld & rq_st)))
        else $error("mc_port_arbiter: rq_ld and rq_st both high on a port");
    end
  end
`endif

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter (PORTS=2, MAX_OUTSTANDING=2) with request and
// response scoreboards aligned to the cycle in which each result is due.
module tb_mc_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   rq_ld, rq_st, rq_stall, rs_push, rs_stall;
  logic [95:0]  rq_vadr;
  logic [127:0] rq_wrd_rdctl;
  logic [31:0]  rs_rdctl;
  logic [63:0]  rs_data;
  logic         mc_req_ld, mc_req_st, mc_req_stall;
  logic [47:0]  mc_req_vadr;
  logic [63:0]  mc_req_wrd_rdctl;
  logic         mc_rsp_push, mc_rsp_stall;
  logic [31:0]  mc_rsp_rdctl;
  logic [63:0]  mc_rsp_data;

  always #5 clk = ~clk;

  mc_port_arbiter #(
    .PORTS           (2),
    .ID_WIDTH        (1),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rq_ld            (rq_ld),
    .rq_st            (rq_st),
    .rq_vadr          (rq_vadr),
    .rq_wrd_rdctl     (rq_wrd_rdctl),
    .rq_stall         (rq_stall),
    .rs_push          (rs_push),
    .rs_rdctl         (rs_rdctl),
    .rs_data          (rs_data),
    .rs_stall         (rs_stall),
    .mc_req_ld        (mc_req_ld),
    .mc_req_st        (mc_req_st),
    .mc_req_vadr      (mc_req_vadr),
    .mc_req_wrd_rdctl (mc_req_wrd_rdctl),
    .mc_req_stall     (mc_req_stall),
    .mc_rsp_push      (mc_rsp_push),
    .mc_rsp_rdctl     (mc_rsp_rdctl),
    .mc_rsp_data      (mc_rsp_data),
    .mc_rsp_stall     (mc_rsp_stall)
  );

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [47:0] vadr;
    logic [63:0] wrd;
  } req_t;

  typedef struct packed {
    logic [1:0]  push;
    logic [31:0] rdctl;
    logic [63:0] data;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  rsp_t rsp_due[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
  endtask

  task automatic set_port(input int p, input logic ld, input logic st,
                          input logic [47:0] va, input logic [63:0] wd);
    rq_ld[p] = ld;
    rq_st[p] = st;
    rq_vadr[48*p +: 48] = va;
    rq_wrd_rdctl[64*p +: 64] = wd;
  endtask

  task automatic exp_req(input logic ld, input logic st,
                         input logic [47:0] va, input logic [63:0] wd);
    req_t e;
    e.ld = ld; e.st = st; e.vadr = va; e.wrd = wd;
    req_q.push_back(e);
  endtask

  task automatic send_rsp(input logic [31:0] rdctl, input logic [63:0] data,
                          input logic [1:0] exp_push, input logic [31:0] exp_rdctl);
    rsp_t r;
    mc_rsp_push  = 1'b1;
    mc_rsp_rdctl = rdctl;
    mc_rsp_data  = data;
    r.push = exp_push; r.rdctl = exp_rdctl; r.data = data;
    rsp_q.push_back(r);
  endtask

  task automatic step(input logic [1:0] exp_stall);
    req_t e;
    rsp_t r;
    @(negedge clk);
    chk("rq_stall", 64'(rq_stall), 64'(exp_stall));
    if (req_q.size() > 0) begin
      e = req_q.pop_front();
      chk("req_ld",   64'(mc_req_ld),        64'(e.ld));
      chk("req_st",   64'(mc_req_st),        64'(e.st));
      chk("req_vadr", 64'(mc_req_vadr),      64'(e.vadr));
      chk("req_wrd",  mc_req_wrd_rdctl,      e.wrd);
    end else begin
      chk("req_idle", 64'({mc_req_ld, mc_req_st}), 64'(0));
    end
    if (rsp_due.size() > 0) begin
      r = rsp_due.pop_front();
      chk("rs_push",  64'(rs_push),  64'(r.push));
      chk("rs_rdctl", 64'(rs_rdctl), 64'(r.rdctl));
      chk("rs_data",  rs_data,       r.data);
    end else begin
      chk("rs_idle", 64'(rs_push), 64'(0));
    end
    @(posedge clk);
    rsp_due = rsp_q;
    rsp_q.delete();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rq_ld = 2'b11; rq_st = 2'b00; rq_vadr = '0; rq_wrd_rdctl = '0;
    rs_stall = 2'b00; mc_req_stall = 1'b0;
    mc_rsp_push = 1'b0; mc_rsp_rdctl = '0; mc_rsp_data = '0;

    // reset state
    step(2'b11);
    chk("rst_vadr",      64'(mc_req_vadr), 64'(0));
    chk("rst_wrd",       mc_req_wrd_rdctl, 64'(0));
    chk("rst_rs_rdctl",  64'(rs_rdctl), 64'(0));
    chk("rst_rs_data",   rs_data, 64'(0));
    chk("rst_rsp_stall", 64'(mc_rsp_stall), 64'(0));
    rq_ld = 2'b00;
    rst = 1'b1;

    // both ports load: alternate 0,1,0,1 then both at limit
    set_port(0, 1'b1, 1'b0, 48'h100, 64'h0000_0011_0000_0001);
    set_port(1, 1'b1, 1'b0, 48'h200, 64'h0000_0022_0000_0005);
    exp_req(1'b1, 1'b0, 48'h100, 64'h0000_0011_0000_0001); step(2'b10);
    exp_req(1'b1, 1'b0, 48'h200, 64'h0000_0022_8000_0005); step(2'b01);
    exp_req(1'b1, 1'b0, 48'h100, 64'h0000_0011_0000_0001); step(2'b10);
    exp_req(1'b1, 1'b0, 48'h200, 64'h0000_0022_8000_0005); step(2'b01);
    step(2'b11);
    rq_ld = 2'b00;

    // responses routed by tag, tag stripped
    send_rsp(32'h8000_0005, 64'hDEAD, 2'b10, 32'h0000_0005);
    step(2'b11);
    send_rsp(32'h0000_0001, 64'hBEEF, 2'b01, 32'h0000_0001);
    step(2'b11);
    mc_rsp_push = 1'b0;
    rs_stall = 2'b10;
    step(2'b11);
    chk("rsp_stall_set", 64'(mc_rsp_stall), 64'(1));
    rs_stall = 2'b00;
    step(2'b11);
    chk("rsp_stall_clr", 64'(mc_rsp_stall), 64'(0));

    // store granted while port 1 sits at its load limit
    set_port(1, 1'b1, 1'b0, 48'h300, 64'h0000_0000_0000_0007);
    exp_req(1'b1, 1'b0, 48'h300, 64'h0000_0000_8000_0007); step(2'b01);
    set_port(0, 1'b0, 1'b1, 48'h40, 64'h1234_5678_9ABC_DEF0);
    exp_req(1'b0, 1'b1, 48'h40, 64'h1234_5678_9ABC_DEF0); step(2'b10);
    set_port(0, 1'b0, 1'b0, 48'h0, 64'h0);
    step(2'b11);
    send_rsp(32'h8000_0007, 64'h77, 2'b10, 32'h0000_0007);
    step(2'b11);
    mc_rsp_push = 1'b0;
    exp_req(1'b1, 1'b0, 48'h300, 64'h0000_0000_8000_0007); step(2'b01);
    rq_ld = 2'b00;

    // fresh reset, then outstanding limit on port 0
    rst = 1'b0;
    step(2'b11);
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 48'h500, 64'h9);
    exp_req(1'b1, 1'b0, 48'h500, 64'h9); step(2'b10);
    exp_req(1'b1, 1'b0, 48'h500, 64'h9); step(2'b10);
    set_port(1, 1'b1, 1'b0, 48'h600, 64'hA);
    exp_req(1'b1, 1'b0, 48'h600, 64'h8000_000A); step(2'b01);
    rq_ld[1] = 1'b0;
    step(2'b11);
    send_rsp(32'h0000_0007, 64'h70, 2'b01, 32'h0000_0007);
    step(2'b11);
    mc_rsp_push = 1'b0;
    exp_req(1'b1, 1'b0, 48'h500, 64'h9); step(2'b10);
    rq_ld = 2'b00;

    // controller stall for 5 cycles, then order resumes from rr (port 1)
    mc_req_stall = 1'b1;
    set_port(0, 1'b0, 1'b1, 48'h700, 64'hAA);
    set_port(1, 1'b0, 1'b1, 48'h800, 64'hBB);
    repeat (5) step(2'b11);
    mc_req_stall = 1'b0;
    exp_req(1'b0, 1'b1, 48'h800, 64'hBB); step(2'b01);
    exp_req(1'b0, 1'b1, 48'h700, 64'hAA); step(2'b10);
    rq_st = 2'b00;

    // reset with 3 loads outstanding; late response must not underflow the count
    set_port(0, 1'b1, 1'b0, 48'h900, 64'h4);
    set_port(1, 1'b1, 1'b0, 48'hA00, 64'h5);
    rst = 1'b0;
    step(2'b11);
    chk("rst2_vadr", 64'(mc_req_vadr), 64'(0));
    chk("rst2_wrd",  mc_req_wrd_rdctl, 64'(0));
    rst = 1'b1;
    rq_ld = 2'b00;
    send_rsp(32'h0000_0003, 64'h33, 2'b01, 32'h0000_0003);
    step(2'b11);
    mc_rsp_push = 1'b0;
    rq_ld[0] = 1'b1;
    exp_req(1'b1, 1'b0, 48'h900, 64'h4); step(2'b10);
    exp_req(1'b1, 1'b0, 48'h900, 64'h4); step(2'b10);
    step(2'b11);
    rq_ld = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
